// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access size encodings,
// FSM state type and wait-state counter width.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  // Wide enough for WAIT_STATES in 0..15
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/load_align.sv
// Load alignment: picks the addressed byte/half out of a storage word
// (little-endian lanes) and zero- or sign-extends it to 32 bits.
module load_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection and extension
  always_comb begin
    case (i_offset)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
    o_data = '0;
    case (i_size)
      SIZE_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
      SIZE_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
      SIZE_WORD: o_data = i_word;
      default:   o_data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: single-outstanding load/store slave with a
// programmable number of wait states and a held response.
// Optional macro DMEM_ALIGN_CHECK_EN: misaligned half/word accesses report
// rsp_err instead of being force-aligned.
//
// state   | meaning
// IDLE    | req_ready high, waiting for a request
// WAIT    | request latched, counting down wait states
// RESP    | response presented, held until rsp_ready
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

  dmem_state_t r_state, w_state_nxt;
  logic [WAIT_CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic          r_write;
  logic [1:0]    r_size;
  logic          r_signed;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;

  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_idle;
  logic          w_accept;
  logic          w_exec;
  logic          w_acc_write;
  logic [1:0]    w_acc_size;
  logic          w_acc_signed;
  logic [AW+1:0] w_acc_addr;
  logic [31:0]   w_acc_wdata;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_off;
  logic          w_err;
  logic [31:0]   w_word;
  logic [31:0]   w_wmerged;
  logic [31:0]   w_load;
  logic          w_unused_addr;

  // Address bits above the storage range are intentionally dropped (wrap)
  assign w_unused_addr = ^req_addr[31:AW+2];

  assign w_idle    = (r_state == ST_IDLE);
  assign w_accept  = req_valid && w_idle;
  assign req_ready = w_idle;
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  // With zero wait states the access executes on the accept edge, so the
  // live request fields are used instead of the latched copy.
  assign w_acc_write  = w_idle ? req_write           : r_write;
  assign w_acc_size   = w_idle ? req_size            : r_size;
  assign w_acc_signed = w_idle ? req_signed          : r_signed;
  assign w_acc_addr   = w_idle ? req_addr[AW+1:0]    : r_addr;
  assign w_acc_wdata  = w_idle ? req_wdata           : r_wdata;
  assign w_idx        = w_acc_addr[AW+1:2];
  assign w_word       = r_mem[w_idx];

  // State and wait counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; w_exec marks the edge on which the access takes effect
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_exec      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            w_exec      = 1'b1;
            w_state_nxt = ST_RESP;
          end else begin
            w_cnt_nxt   = WAIT_INIT;
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt <= WAIT_CNT_W'(1)) begin
          w_cnt_nxt   = '0;
          w_exec      = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch request fields on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write  <= 1'b0;
      r_size   <= SIZE_BYTE;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else if (w_accept) begin
      r_write  <= req_write;
      r_size   <= req_size;
      r_signed <= req_signed;
      r_addr   <= req_addr[AW+1:0];
      r_wdata  <= req_wdata;
    end
  end

  // Error detection and effective byte offset
  always_comb begin
    w_off = w_acc_addr[1:0];
    w_err = (w_acc_size == SIZE_RSVD);
`ifdef DMEM_ALIGN_CHECK_EN
    if ((w_acc_size == SIZE_HALF) && w_acc_addr[0]) w_err = 1'b1;
    if ((w_acc_size == SIZE_WORD) && (w_acc_addr[1:0] != 2'b00)) w_err = 1'b1;
`else
    if (w_acc_size == SIZE_HALF) w_off[0] = 1'b0;
    if (w_acc_size == SIZE_WORD) w_off = 2'b00;
`endif
  end

  // Merge store data into the addressed byte lanes
  always_comb begin
    w_wmerged = w_word;
    case (w_acc_size)
      SIZE_BYTE: begin
        case (w_off)
          2'd0:    w_wmerged[7:0]   = w_acc_wdata[7:0];
          2'd1:    w_wmerged[15:8]  = w_acc_wdata[7:0];
          2'd2:    w_wmerged[23:16] = w_acc_wdata[7:0];
          default: w_wmerged[31:24] = w_acc_wdata[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (w_off[1]) w_wmerged[31:16] = w_acc_wdata[15:0];
        else          w_wmerged[15:0]  = w_acc_wdata[15:0];
      end
      SIZE_WORD: w_wmerged = w_acc_wdata;
      default:   w_wmerged = w_word;
    endcase
  end

  load_align u_load_align (
    .i_word   (w_word),
    .i_offset (w_off),
    .i_size   (w_acc_size),
    .i_signed (w_acc_signed),
    .o_data   (w_load)
  );

  // Storage commit; contents survive reset, and nothing commits while in reset
  always_ff @(posedge clk) begin
    if (rst_n && w_exec && w_acc_write && !w_err) r_mem[w_idx] <= w_wmerged;
  end

  // Response data/error captured when the access executes, held through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_exec) begin
      r_err   <= w_err;
      r_rdata <= (w_acc_write || w_err) ? 32'h0 : w_load;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
`timescale 1ns/1ps
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int WS    = 1;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam logic [31:0] LH11_D = 32'h0;
  localparam logic        LH11_E = 1'b1;
  localparam logic [31:0] LH13_D = 32'h0;
  localparam logic        LH13_E = 1'b1;
  localparam logic        SW12_E = 1'b1;
  localparam logic [31:0] LW10_F = 32'h8000_0000;
`else
  localparam logic [31:0] LH11_D = 32'h0;
  localparam logic        LH11_E = 1'b0;
  localparam logic [31:0] LH13_D = 32'hFFFF_8000;
  localparam logic        LH13_E = 1'b0;
  localparam logic        SW12_E = 1'b0;
  localparam logic [31:0] LW10_F = 32'hCAFE_F00D;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  vec_t vecs[$];
  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] er, input logic ee);
    vec_t v;
    v.wr = wr; v.sz = sz; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_size   = v.sz;
    req_signed = v.sgn;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
  endtask

  task automatic do_req(input vec_t v, input int idx);
    int   n;
    rsp_t e;
    @(negedge clk);
    drive(v);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL vec%0d accept timeout", idx);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back('{rdata: v.exp_rdata, err: v.exp_err});
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    chk($sformatf("vec%0d latency", idx), 32'(n), 32'(WS));
    if (!rsp_valid) begin
      void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    chk($sformatf("vec%0d rdata", idx), rsp_rdata, e.rdata);
    chk($sformatf("vec%0d err", idx), 32'(rsp_err), 32'(e.err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rsp_t e;
    int   n;

    vecs.push_back(mk(1, 2'b10, 0, 32'h10,   32'hDEAD_BEEF, 32'h0,         0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10,   32'h0,         32'hDEAD_BEEF, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h10,   32'h0,         32'h0000_00EF, 0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h11,   32'h0,         32'hFFFF_FFBE, 0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h12,   32'h0,         32'hFFFF_DEAD, 0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h10,   32'h0,         32'h0000_BEEF, 0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h10,   32'h0,         32'h0,         0));
    vecs.push_back(mk(1, 2'b00, 0, 32'h13,   32'hAAAA_AA80, 32'h0,         0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h13,   32'h0,         32'hFFFF_FF80, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h13,   32'h0,         32'h0000_0080, 0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10,   32'h0,         32'h8000_0000, 0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h14,   32'h1122_3344, 32'h0,         0));
    vecs.push_back(mk(1, 2'b01, 0, 32'h16,   32'h5555_ABCD, 32'h0,         0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h14,   32'h0,         32'hABCD_3344, 0));
    vecs.push_back(mk(0, 2'b11, 0, 32'h10,   32'h0,         32'h0,         1));
    vecs.push_back(mk(1, 2'b11, 0, 32'h10,   32'hFFFF_FFFF, 32'h0,         1));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10,   32'h0,         32'h8000_0000, 0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h1010, 32'h0,         32'h8000_0000, 0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h1014, 32'h0BAD_F00D, 32'h0,         0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h14,   32'h0,         32'h0BAD_F00D, 0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h11,   32'h0,         LH11_D,        LH11_E));
    vecs.push_back(mk(0, 2'b01, 1, 32'h13,   32'h0,         LH13_D,        LH13_E));
    vecs.push_back(mk(1, 2'b10, 0, 32'h12,   32'hCAFE_F00D, 32'h0,         SW12_E));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10,   32'h0,         LW10_F,        0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h20,   32'h1111_1111, 32'h0,         0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h20,   32'h0,         32'h1111_1111, 0));

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) do_req(vecs[i], i);

    // Backpressure: response held, stray request ignored
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(mk(0, 2'b10, 0, 32'h14, 32'h0, 32'h0, 0));
    @(posedge clk);
    exp_q.push_back('{rdata: 32'h0BAD_F00D, err: 1'b0});
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    chk("bp latency", 32'(n), 32'(WS));
    drive(mk(1, 2'b10, 0, 32'h14, 32'hFFFF_FFFF, 32'h0, 0));
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d rdata", i), rsp_rdata, 32'h0BAD_F00D);
      chk($sformatf("bp%0d req_ready", i), 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    e = exp_q.pop_front();
    chk("bp rdata", rsp_rdata, e.rdata);
    chk("bp err", 32'(rsp_err), 32'(e.err));
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp post rsp_valid", 32'(rsp_valid), 32'd0);
    chk("bp post req_ready", 32'(req_ready), 32'd1);
    do_req(mk(0, 2'b10, 0, 32'h14, 32'h0, 32'h0BAD_F00D, 0), 100);

    // Reset during WAIT of a store drops it
    @(negedge clk);
    drive(mk(1, 2'b10, 0, 32'h20, 32'h1234_5678, 32'h0, 0));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstw rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstw rsp_rdata", rsp_rdata, 32'h0);
    chk("rstw rsp_err", 32'(rsp_err), 32'd0);
    chk("rstw req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_req(mk(0, 2'b10, 0, 32'h20, 32'h0, 32'h1111_1111, 0), 101);

    chk("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
